bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: hands the CPU bus to a single DMA/boot requester through a
// BR / BG / BGACK handshake. The arbiter does not release the bus into a
// new tenure until any CPU cycle that is in progress (AS) has finished.
// The FSM has four states: IDLE -> REQUEST -> OWN -> RELEASE -> IDLE.
// Three saturating counters bound the time spent in each state:
// the wait for a grant, the length of ownership, and the gap after release.
// All state changes on the falling edge of MCLK_IN. RUN_IN is an
// asynchronous, active-low reset.
module bus_arbiter #(
  parameter int unsigned TENURE_MAX    = 256,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned GRANT_TIMEOUT = 64
) (
  input  logic       MCLK_IN,
  input  logic       RUN_IN,
  input  logic       DMA_REQ_IN,
  input  logic       BG_IN,
  input  logic       AS_IN,
  output logic       BR,
  output logic       BGACK,
  output logic       DMA_GRANT,
  output logic       TIMEOUT_ERR,
  output logic       TENURE_EXPIRED,
  output logic [2:0] STATE_OUT
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQUEST = 3'd1;
  localparam logic [2:0] S_OWN     = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;

  // Terminal counts. A counter that sits at *_LAST on an edge ends its
  // state on that edge. This gives exactly TENURE_MAX / GAP_CYCLES cycles.
  localparam logic [15:0] TEN_LAST = 16'(TENURE_MAX - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TO_LIM   = 16'(GRANT_TIMEOUT);

  logic [2:0]  state, state_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic [15:0] ten_cnt, ten_nxt;
  logic [15:0] gap_cnt, gap_nxt;
  logic        to_nxt, te_nxt;
  logic        own_q;
  logic [15:0] wait_inc;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign wait_inc = sat_inc(wait_cnt);

  // Next-state and counter update. In REQUEST, the priority order is:
  // withdrawal first, then grant, then timeout.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    ten_nxt   = ten_cnt;
    gap_nxt   = gap_cnt;
    to_nxt    = 1'b0;
    te_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (DMA_REQ_IN) begin
          state_nxt = S_REQUEST;
          wait_nxt  = '0;
        end
      end
      S_REQUEST: begin
        if (!DMA_REQ_IN) begin
          state_nxt = S_RELEASE;
          gap_nxt   = '0;
        end else if (BG_IN && !AS_IN) begin
          state_nxt = S_OWN;
          ten_nxt   = '0;
        end else if (wait_inc >= TO_LIM) begin
          state_nxt = S_RELEASE;
          gap_nxt   = '0;
          wait_nxt  = wait_inc;
          to_nxt    = 1'b1;
        end else begin
          // No grant yet, or the CPU cycle is still running: keep BR up.
          wait_nxt = wait_inc;
        end
      end
      S_OWN: begin
        if (!DMA_REQ_IN) begin
          // A voluntary drop wins over expiry on the same edge, so no pulse.
          state_nxt = S_RELEASE;
          gap_nxt   = '0;
        end else if (ten_cnt >= TEN_LAST) begin
          state_nxt = S_RELEASE;
          gap_nxt   = '0;
          te_nxt    = 1'b1;
        end else begin
          ten_nxt = sat_inc(ten_cnt);
        end
      end
      S_RELEASE: begin
        // The gap runs to completion whether or not the request is held.
        if (gap_cnt >= GAP_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          gap_nxt = sat_inc(gap_cnt);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        wait_nxt  = '0;
        ten_nxt   = '0;
        gap_nxt   = '0;
      end
    endcase
  end

  // State, counters and pulses. Async reset drops everything at once.
  always_ff @(negedge MCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      ten_cnt        <= '0;
      gap_cnt        <= '0;
      TIMEOUT_ERR    <= 1'b0;
      TENURE_EXPIRED <= 1'b0;
    end else begin
      state          <= state_nxt;
      wait_cnt       <= wait_nxt;
      ten_cnt        <= ten_nxt;
      gap_cnt        <= gap_nxt;
      TIMEOUT_ERR    <= to_nxt;
      TENURE_EXPIRED <= te_nxt;
    end
  end

  // Handshake outputs are decoded from the next state and then registered.
  // Because REQUEST and OWN are exclusive, BR and BGACK are never both high.
  always_ff @(negedge MCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      BR    <= 1'b0;
      own_q <= 1'b0;
    end else begin
      BR    <= (state_nxt == S_REQUEST);
      own_q <= (state_nxt == S_OWN);
    end
  end

  // BGACK and DMA_GRANT come from one flop, so they cannot disagree.
  assign BGACK     = own_q;
  assign DMA_GRANT = own_q;
  assign STATE_OUT = state;

endmodule
